// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator slice.
// Holds the FSM state encoding, the product width and the counter-width helper.
package product_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int PROD_W = 8;

  // Wide enough to hold 0..count_n, since cnt reaches COUNT_N on a full group.
  function automatic int cnt_width(input int count_n);
    return $clog2(count_n + 1);
  endfunction

endpackage

// File: rtl/product_accumulator_acc.sv
// Accumulator adder: ACC_W-bit sum of the running total and a zero-extended product.
// Build option PRODUCT_ACCUMULATOR_SATURATE_EN clamps the sum to all-ones on carry-out.
module acc_adder
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] addend,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
  assign carry    = full_sum[ACC_W];

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  // Once clamped, any further nonzero product carries again, so acc stays at max.
  assign sum = carry ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
  assign sum = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of COUNT_N unsigned products (or fewer when in_last closes early) and
// presents each sum once on a valid/ready port. Saturation via PRODUCT_ACCUMULATOR_SATURATE_EN.
//
//   state | meaning
//   IDLE  | post-reset, not ready; leaves on the next edge
//   ACCUM | in_ready=1, adding accepted products
//   HOLD  | out_valid=1, result stable until out_ready
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int COUNT_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_p,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf
);

  localparam int CNT_W = cnt_width(COUNT_N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT_N - 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             ovf, carry;
  logic             accept, closing, res_taken;

  acc_adder #(.ACC_W(ACC_W)) u_adder (
    .acc    (acc),
    .addend (in_p),
    .sum    (acc_sum),
    .carry  (carry)
  );

  assign accept    = in_valid & in_ready;
  assign closing   = accept & ((cnt == LAST_CNT) | in_last);
  assign res_taken = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:  state_nxt = ACCUM;
      ACCUM: begin
        in_ready = 1'b1;
        if (closing) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (res_taken) state_nxt = ACCUM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (res_taken) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_sum;
      cnt <= cnt + CNT_W'(1);
      ovf <= ovf | carry;
    end
  end

  assign out_acc = acc;
  assign out_ovf = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: group-level sum model for two DUT configurations
// (16-bit/4-per-group and 10-bit/8-per-group) plus hand-computed literal results.
module tb_product_accumulator;

  localparam int AW [2] = '{16, 10};
  localparam int CN [2] = '{4, 8};

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_p      [2];
  logic       in_last   [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic       out_ovf   [2];
  logic [15:0] out_acc0;
  logic [9:0]  out_acc1;

  int vectors = 0;
  int errors  = 0;

  // model: phase 0 = not yet ready, 1 = taking products, 2 = result held
  int     m_ph  [2] = '{0, 0};
  longint m_sum [2] = '{0, 0};
  int     m_n   [2] = '{0, 0};

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(16), .COUNT_N(4)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_p(in_p[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_acc(out_acc0), .out_ovf(out_ovf[0])
  );

  product_accumulator #(.ACC_W(10), .COUNT_N(8)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_p(in_p[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_acc(out_acc1), .out_ovf(out_ovf[1])
  );

  function automatic longint dut_acc(input int i);
    return (i == 0) ? longint'(out_acc0) : longint'(out_acc1);
  endfunction

  function automatic longint exp_acc(input int i);
    longint maxv = (longint'(1) << AW[i]) - 1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    return (m_sum[i] > maxv) ? maxv : m_sum[i];
`else
    return m_sum[i] % (maxv + 1);
`endif
  endfunction

  function automatic logic exp_ovf(input int i);
    return m_sum[i] > ((longint'(1) << AW[i]) - 1);
  endfunction

  task automatic check(input string name, input int i, input longint act, input longint req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", name, i, act, req, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_ph[i]  <= 0;
        m_sum[i] <= 0;
        m_n[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (m_ph[i])
          0: m_ph[i] <= 1;
          1: if (in_valid[i]) begin
               m_sum[i] <= m_sum[i] + longint'(in_p[i]);
               m_n[i]   <= m_n[i] + 1;
               if (m_n[i] + 1 == CN[i] || in_last[i]) m_ph[i] <= 2;
             end
          default: if (out_ready[i]) begin
               m_ph[i]  <= 1;
               m_sum[i] <= 0;
               m_n[i]   <= 0;
             end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check("in_ready", i, longint'(in_ready[i]), longint'(m_ph[i] == 1));
      check("out_valid", i, longint'(out_valid[i]), longint'(m_ph[i] == 2));
      if (m_ph[i] == 2) begin
        check("out_acc", i, dut_acc(i), exp_acc(i));
        check("out_ovf", i, longint'(out_ovf[i]), longint'(exp_ovf(i)));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input int i, input int p, input bit last);
    int n = 0;
    in_valid[i] = 1'b1;
    in_p[i]     = 8'(p);
    in_last[i]  = last;
    while (!in_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", i, 0, 1);
    @(negedge clk);
    in_valid[i] = 1'b0;
    in_last[i]  = 1'b0;
  endtask

  task automatic take(input int i, input longint acc_req, input bit ovf_req,
                      input int wait_req, input string name);
    int n = 0;
    out_ready[i] = 1'b1;
    while (!out_valid[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_wait"}, i, n, wait_req);
    check({name, "_acc"}, i, dut_acc(i), acc_req);
    check({name, "_ovf"}, i, longint'(out_ovf[i]), longint'(ovf_req));
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    for (int i = 0; i < 2; i++) begin
      check({name, "_in_ready"}, i, longint'(in_ready[i]), 0);
      check({name, "_out_valid"}, i, longint'(out_valid[i]), 0);
      check({name, "_out_acc"}, i, dut_acc(i), 0);
      check({name, "_out_ovf"}, i, longint'(out_ovf[i]), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_p[i] = '0; in_last[i] = 1'b0; out_ready[i] = 1'b1;
    end
    #1 rst = 1'b1;
    #2 check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("ready_after_release", 0, longint'(in_ready[0]), 0);
    @(negedge clk);
    check("ready_one_cycle_later", 0, longint'(in_ready[0]), 1);

    // full group of four 225s; result visible right after the 4th accept
    for (int k = 0; k < 4; k++) send(0, 225, 1'b0);
    take(0, 900, 1'b0, 0, "full_group");

    // early close, then a fresh group starting from zero
    send(0, 3, 1'b0); send(0, 5, 1'b0); send(0, 7, 1'b1);
    take(0, 15, 1'b0, 0, "early_close");
    for (int k = 0; k < 4; k++) send(0, 1, k == 3);
    take(0, 4, 1'b0, 0, "last_on_nth");
    send(0, 2, 1'b0); send(0, 2, 1'b1);
    take(0, 4, 1'b0, 0, "after_last_on_nth");

    // overflow on the 10-bit, 8-per-group instance
    for (int k = 0; k < 8; k++) send(1, 255, 1'b0);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    take(1, 1023, 1'b1, 0, "overflow");
`else
    take(1, 1016, 1'b1, 0, "overflow");
`endif

    // backpressure: result held with in_valid high, then one transfer
    out_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 50, 1'b0);
    in_valid[0] = 1'b1; in_p[0] = 8'd9; in_last[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ready", 0, longint'(in_ready[0]), 0);
      check("bp_out_valid", 0, longint'(out_valid[0]), 1);
      check("bp_out_acc", 0, dut_acc(0), 200);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_one_transfer", 0, longint'(out_valid[0]), 0);
    @(negedge clk);
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    check("bp_next_group", 0, dut_acc(0), 9);
    @(negedge clk);

    // gapped input
    for (int k = 1; k <= 4; k++) begin
      send(0, k, 1'b0);
      if (k < 4) @(negedge clk);
    end
    take(0, 10, 1'b0, 0, "gapped");

    // reset mid-group
    send(0, 20, 1'b0); send(0, 30, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    check("ready_after_mid_release", 0, longint'(in_ready[0]), 0);
    @(negedge clk);
    check("ready_after_mid_reset", 0, longint'(in_ready[0]), 1);
    for (int k = 0; k < 4; k++) send(0, 10, 1'b0);
    take(0, 40, 1'b0, 0, "post_reset");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
